// File: rtl/sample_framer.sv
// sample_framer: ping-pong frame buffer that collects samples and hands full frames to an FFT
module sample_framer #(
  parameter int WIDTH = 12,
  parameter int N = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] frame_out [0:N-1],
  output logic             fft_start,
  output logic             fft_clear,
  input  logic             fft_done,
  output logic             overflow,
  output logic [7:0]       drop_count
);
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, START, BUSY, CLEAR} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] bank [0:1][0:N-1];
  logic [1:0] full;
  logic wr_bank, rd_bank;
  logic [IW-1:0] wr_idx;
  logic accept, drop, last;
  assign accept = sample_valid && !full[wr_bank];
  assign drop = sample_valid && full[wr_bank];
  assign last = &wr_idx;
  assign fft_start = state == START;
  assign fft_clear = state == CLEAR;
  // sample storage: a full bank never accepts writes, so the bank under FFT stays frozen
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < N; k++)
          bank[b][k] <= '0;
    end else if (accept)
      bank[wr_bank][wr_idx] <= sample_in;
  // write pointer, full flags (set by the last write, cleared on CLEAR exit) and drop statistics
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_bank <= 1'b0;
      wr_idx <= '0;
      full <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      if (accept) begin
        wr_idx <= wr_idx + 1'b1;
        if (last) wr_bank <= !wr_bank;
      end
      for (int b = 0; b < 2; b++)
        full[b] <= (full[b] | (accept && last && wr_bank == 1'(b))) & !(fft_clear && rd_bank == 1'(b));
      if (drop) begin
        overflow <= 1'b1;
        drop_count <= drop_count + {7'd0, ~&drop_count};
      end
    end
  // read FSM state and read bank pointer, which advances as CLEAR hands the bank back
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      rd_bank <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) rd_bank <= !rd_bank;
    end
  // next state: fft_done only matters while BUSY
  always_comb
    state_nxt = state == IDLE  ? (full[rd_bank] ? START : IDLE) :
                state == START ? BUSY :
                state == BUSY  ? (fft_done ? CLEAR : BUSY) : IDLE;
  // the FFT always sees the bank currently owned by the read side
  always_comb
    for (int k = 0; k < N; k++)
      frame_out[k] = bank[rd_bank][k];
endmodule
